// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller with direction-collective (SCAN) scheduling,
// door hold/reopen and per-floor travel timing.
module elevator_scan_ctrl #(
    parameter int N_FLOORS   = 8,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 6,
    localparam int F_BITS    = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] ext_up,
    input  logic [N_FLOORS-1:0] ext_down,
    input  logic [N_FLOORS-1:0] ext_floor,
    input  logic                door_hold,
    output logic [F_BITS-1:0]   cur_floor,
    output logic [1:0]          cur_cmd,
    output logic                doors_open,
    output logic                dir,
    output logic [N_FLOORS-1:0] u_buttons,
    output logic [N_FLOORS-1:0] d_buttons,
    output logic [N_FLOORS-1:0] f_buttons
);

    localparam int T_BITS = $clog2(TRAVEL_CYC + 1);
    localparam int D_BITS = $clog2(DOOR_CYC + 1);
    localparam logic [T_BITS-1:0] T_LAST = T_BITS'(TRAVEL_CYC - 1);
    localparam logic [D_BITS-1:0] D_LOAD = D_BITS'(DOOR_CYC);
    // No hall-up call exists at the top floor, no hall-down call at floor 0.
    localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t              r_state;
    logic [F_BITS-1:0]   r_floor;
    logic                r_dir;
    logic [T_BITS-1:0]   r_travel;
    logic [D_BITS-1:0]   r_dwell;
    logic [N_FLOORS-1:0] r_u, r_d, r_f;

    state_t              w_nxt_state;
    logic [F_BITS-1:0]   w_nxt_floor, w_arr, w_serve_floor;
    logic                w_nxt_dir, w_serve, w_rev, w_stop;
    logic [T_BITS-1:0]   w_nxt_travel;
    logic [D_BITS-1:0]   w_nxt_dwell;
    logic [N_FLOORS-1:0] w_pending, w_cur_oh, w_arr_oh, w_serve_oh;
    logic [N_FLOORS-1:0] w_clr_u, w_clr_d, w_clr_f, w_abs_u, w_abs_d, w_abs_f;
    logic                w_here, w_above, w_below;

    function automatic logic f_beyond(input logic [N_FLOORS-1:0] p,
                                      input logic [F_BITS-1:0] f,
                                      input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (p[i] && (up ? (i > int'(f)) : (i < int'(f))))
                r = 1'b1;
        return r;
    endfunction

    function automatic logic [N_FLOORS-1:0] f_onehot(input logic [F_BITS-1:0] f);
        logic [N_FLOORS-1:0] r;
        for (int i = 0; i < N_FLOORS; i++)
            r[i] = (int'(f) == i);
        return r;
    endfunction

    assign w_pending = r_u | r_d | r_f;
    assign w_cur_oh  = f_onehot(r_floor);
    assign w_here    = |(w_pending & w_cur_oh);
    assign w_above   = f_beyond(w_pending, r_floor, 1'b1);
    assign w_below   = f_beyond(w_pending, r_floor, 1'b0);
    assign w_arr     = r_dir ? (r_floor + F_BITS'(1)) : (r_floor - F_BITS'(1));
    assign w_arr_oh  = f_onehot(w_arr);
    assign w_stop    = (|(r_f & w_arr_oh))
                     | (r_dir & (|(r_u & w_arr_oh)))
                     | (!r_dir & (|(r_d & w_arr_oh)))
                     | !f_beyond(w_pending, w_arr, r_dir);

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_floor   = r_floor;
        w_nxt_dir     = r_dir;
        w_nxt_travel  = r_travel;
        w_nxt_dwell   = r_dwell;
        w_serve       = 1'b0;
        w_serve_floor = r_floor;
        w_serve_oh    = '0;
        w_rev         = 1'b0;
        w_abs_u       = '0;
        w_abs_d       = '0;
        w_abs_f       = '0;
        w_clr_u       = '0;
        w_clr_d       = '0;
        w_clr_f       = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_here) begin
                    w_nxt_state = S_DOOR;
                    w_serve     = 1'b1;
                end else if (w_above || w_below) begin
                    w_nxt_state  = S_MOVE;
                    w_nxt_travel = '0;
                    if (!(w_above && w_below))
                        w_nxt_dir = w_above;
                end
            end
            S_MOVE: begin
                if (r_travel == T_LAST) begin
                    w_nxt_travel = '0;
                    w_nxt_floor  = w_arr;
                    if (w_stop) begin
                        w_nxt_state   = S_DOOR;
                        w_serve       = 1'b1;
                        w_serve_floor = w_arr;
                    end
                end else begin
                    w_nxt_travel = r_travel + T_BITS'(1);
                end
            end
            S_DOOR: begin
                // Calls at this floor in the service direction just reopen the doors.
                w_abs_f = ext_floor & w_cur_oh;
                w_abs_u = r_dir ? (ext_up & w_cur_oh & UP_MASK) : '0;
                w_abs_d = r_dir ? '0 : (ext_down & w_cur_oh & DN_MASK);
                if (door_hold || (|{w_abs_f, w_abs_u, w_abs_d})) begin
                    w_nxt_dwell = D_LOAD;
                end else if (r_dwell <= D_BITS'(1)) begin
                    if (f_beyond(w_pending, r_floor, r_dir)) begin
                        w_nxt_state  = S_MOVE;
                        w_nxt_travel = '0;
                    end else if (f_beyond(w_pending, r_floor, !r_dir)) begin
                        w_nxt_state  = S_MOVE;
                        w_nxt_travel = '0;
                        w_nxt_dir    = !r_dir;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_dwell = r_dwell - D_BITS'(1);
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        if (w_serve) begin
            w_serve_oh  = f_onehot(w_serve_floor);
            w_rev       = !f_beyond(w_pending, w_serve_floor, r_dir);
            w_clr_f     = w_serve_oh;
            w_clr_u     = (r_dir || w_rev) ? w_serve_oh : '0;
            w_clr_d     = (!r_dir || w_rev) ? w_serve_oh : '0;
            w_nxt_dwell = D_LOAD;
            if (w_rev)
                w_nxt_dir = !r_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_floor  <= '0;
            r_dir    <= 1'b1;
            r_travel <= '0;
            r_dwell  <= '0;
            r_u      <= '0;
            r_d      <= '0;
            r_f      <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_floor  <= w_nxt_floor;
            r_dir    <= w_nxt_dir;
            r_travel <= w_nxt_travel;
            r_dwell  <= w_nxt_dwell;
            // A clear at the served floor beats a same-cycle pulse there.
            r_u      <= (r_u | (ext_up    & UP_MASK & ~w_abs_u)) & ~w_clr_u;
            r_d      <= (r_d | (ext_down  & DN_MASK & ~w_abs_d)) & ~w_clr_d;
            r_f      <= (r_f | (ext_floor & ~w_abs_f)) & ~w_clr_f;
        end
    end

    always_comb begin
        cur_cmd = 2'b00;
        unique case (r_state)
            S_MOVE:  cur_cmd = r_dir ? 2'b01 : 2'b10;
            S_DOOR:  cur_cmd = 2'b11;
            default: cur_cmd = 2'b00;
        endcase
    end

    assign cur_floor  = r_floor;
    assign doors_open = (r_state == S_DOOR);
    assign dir        = r_dir;
    assign u_buttons  = r_u;
    assign d_buttons  = r_d;
    assign f_buttons  = r_f;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: reset, single stop, travel timing,
// SCAN ordering, door hold/reopen and asynchronous reset mid-move.
module tb_elevator_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ext_up, ext_down, ext_floor;
    logic       door_hold;
    logic [2:0] cur_floor;
    logic [1:0] cur_cmd;
    logic       doors_open, dir;
    logic [7:0] u_buttons, d_buttons, f_buttons;

    int cmp = 0;
    int mis = 0;

    elevator_scan_ctrl #(.N_FLOORS(8), .TRAVEL_CYC(4), .DOOR_CYC(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_up(ext_up), .ext_down(ext_down), .ext_floor(ext_floor),
        .door_hold(door_hold),
        .cur_floor(cur_floor), .cur_cmd(cur_cmd), .doors_open(doors_open), .dir(dir),
        .u_buttons(u_buttons), .d_buttons(d_buttons), .f_buttons(f_buttons)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ext_up = 8'hFF; ext_down = 8'hFF; ext_floor = 8'hFF; door_hold = 1'b1;
        tick(); tick();
        cmp++; if (cur_floor !== 3'd0) begin mis++; $display("FAIL rst_floor: got %0d want 0", cur_floor); end
        cmp++; if (cur_cmd !== 2'b00) begin mis++; $display("FAIL rst_cmd: got %b want 00", cur_cmd); end
        cmp++; if (doors_open !== 1'b0 || dir !== 1'b1) begin mis++; $display("FAIL rst_door_dir: got %b%b want 01", doors_open, dir); end
        cmp++; if ({u_buttons, d_buttons, f_buttons} !== 24'h0) begin mis++; $display("FAIL rst_buttons: got %h want 0", {u_buttons, d_buttons, f_buttons}); end
        ext_up = 8'h0; ext_down = 8'h0; ext_floor = 8'h0; door_hold = 1'b0;
        rst_n = 1'b1;
        tick();
        cmp++; if ({u_buttons, d_buttons, f_buttons} !== 24'h0 || cur_cmd !== 2'b00) begin mis++; $display("FAIL rst_release: got %h/%b want 0/00", {u_buttons, d_buttons, f_buttons}, cur_cmd); end
    endtask

    task automatic test_same_floor();
        int n;
        ext_floor = 8'h01; tick(); ext_floor = 8'h00;
        cmp++; if (f_buttons !== 8'h01 || cur_cmd !== 2'b00) begin mis++; $display("FAIL same_latch: got %h/%b want 01/00", f_buttons, cur_cmd); end
        tick();
        cmp++; if (doors_open !== 1'b1 || f_buttons !== 8'h00) begin mis++; $display("FAIL same_entry: got %b/%h want 1/00", doors_open, f_buttons); end
        n = 0;
        while (doors_open === 1'b1 && n < 40) begin tick(); n++; end
        cmp++; if (n !== 6) begin mis++; $display("FAIL same_dwell: got %0d want 6", n); end
        cmp++; if (cur_cmd !== 2'b00 || dir !== 1'b0) begin mis++; $display("FAIL same_idle: got %b/%b want 00/0", cur_cmd, dir); end
    endtask

    task automatic test_travel();
        int n;
        logic [2:0] fl8;
        fl8 = 3'd7;
        ext_floor = 8'h20; tick(); ext_floor = 8'h00;
        cmp++; if (f_buttons !== 8'h20 || cur_cmd !== 2'b00) begin mis++; $display("FAIL trav_latch: got %h/%b want 20/00", f_buttons, cur_cmd); end
        tick();
        cmp++; if (cur_cmd !== 2'b01 || dir !== 1'b1 || cur_floor !== 3'd0) begin mis++; $display("FAIL trav_start: got %b/%b/%0d want 01/1/0", cur_cmd, dir, cur_floor); end
        n = 0;
        while (cur_cmd === 2'b01 && n < 100) begin tick(); n++; if (n == 8) fl8 = cur_floor; end
        cmp++; if (n !== 20) begin mis++; $display("FAIL trav_cycles: got %0d want 20", n); end
        cmp++; if (fl8 !== 3'd2) begin mis++; $display("FAIL trav_mid: got %0d want 2", fl8); end
        cmp++; if (cur_floor !== 3'd5 || cur_cmd !== 2'b11 || f_buttons !== 8'h00) begin mis++; $display("FAIL trav_arrive: got %0d/%b/%h want 5/11/00", cur_floor, cur_cmd, f_buttons); end
        n = 0;
        while (doors_open === 1'b1 && n < 40) begin tick(); n++; end
        cmp++; if (n !== 6 || cur_cmd !== 2'b00) begin mis++; $display("FAIL trav_door: got %0d/%b want 6/00", n, cur_cmd); end
    endtask

    task automatic test_scan();
        int n;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        ext_floor = 8'h40; tick(); ext_floor = 8'h00;
        n = 0;
        while (cur_floor !== 3'd1 && n < 50) begin tick(); n++; end
        ext_down = 8'h08; ext_up = 8'h10; tick(); ext_down = 8'h00; ext_up = 8'h00;
        cmp++; if (u_buttons !== 8'h10 || d_buttons !== 8'h08) begin mis++; $display("FAIL scan_latch: got %h/%h want 10/08", u_buttons, d_buttons); end
        n = 0;
        while (cur_cmd !== 2'b11 && n < 100) begin tick(); n++; end
        cmp++; if (cur_floor !== 3'd4 || u_buttons !== 8'h00 || d_buttons !== 8'h08 || f_buttons !== 8'h40 || dir !== 1'b1)
            begin mis++; $display("FAIL scan_stop4: got fl%0d u%h d%h f%h dir%b want fl4 u00 d08 f40 dir1", cur_floor, u_buttons, d_buttons, f_buttons, dir); end
        n = 0;
        while (cur_cmd === 2'b11 && n < 40) begin tick(); n++; end
        cmp++; if (cur_cmd !== 2'b01) begin mis++; $display("FAIL scan_resume_up: got %b want 01", cur_cmd); end
        n = 0;
        while (cur_cmd !== 2'b11 && n < 100) begin tick(); n++; end
        cmp++; if (cur_floor !== 3'd6 || dir !== 1'b0 || f_buttons !== 8'h00) begin mis++; $display("FAIL scan_stop6: got fl%0d dir%b f%h want fl6 dir0 f00", cur_floor, dir, f_buttons); end
        n = 0;
        while (cur_cmd === 2'b11 && n < 40) begin tick(); n++; end
        cmp++; if (cur_cmd !== 2'b10) begin mis++; $display("FAIL scan_resume_dn: got %b want 10", cur_cmd); end
        n = 0;
        while (cur_cmd !== 2'b11 && n < 100) begin tick(); n++; end
        cmp++; if (cur_floor !== 3'd3 || d_buttons !== 8'h00) begin mis++; $display("FAIL scan_stop3: got fl%0d d%h want fl3 d00", cur_floor, d_buttons); end
        n = 0;
        while (cur_cmd === 2'b11 && n < 40) begin tick(); n++; end
        cmp++; if (cur_cmd !== 2'b00 || {u_buttons, d_buttons, f_buttons} !== 24'h0) begin mis++; $display("FAIL scan_idle: got %b/%h want 00/0", cur_cmd, {u_buttons, d_buttons, f_buttons}); end
    endtask

    task automatic test_door_hold();
        int n;
        ext_floor = 8'h04; tick(); ext_floor = 8'h00;
        n = 0;
        while (cur_cmd !== 2'b11 && n < 100) begin tick(); n++; end
        cmp++; if (cur_floor !== 3'd2 || doors_open !== 1'b1) begin mis++; $display("FAIL hold_arrive: got fl%0d door%b want fl2 door1", cur_floor, doors_open); end
        door_hold = 1'b1;
        n = 0;
        while (doors_open === 1'b1 && n < 100) begin tick(); n++; if (n == 10) door_hold = 1'b0; end
        door_hold = 1'b0;
        cmp++; if (n !== 16) begin mis++; $display("FAIL hold_dwell: got %0d want 16", n); end
        cmp++; if (cur_cmd !== 2'b00) begin mis++; $display("FAIL hold_idle: got %b want 00", cur_cmd); end
    endtask

    task automatic test_reopen();
        int n;
        ext_floor = 8'h04; tick(); ext_floor = 8'h00;
        tick();
        cmp++; if (doors_open !== 1'b1 || f_buttons !== 8'h00) begin mis++; $display("FAIL reopen_entry: got %b/%h want 1/00", doors_open, f_buttons); end
        n = 0;
        while (doors_open === 1'b1 && n < 100) begin
            tick(); n++;
            if (n == 2) ext_floor = 8'h04;
            if (n == 3) begin
                ext_floor = 8'h00;
                cmp++; if (f_buttons !== 8'h00) begin mis++; $display("FAIL reopen_absorb: got %h want 00", f_buttons); end
            end
        end
        cmp++; if (n !== 9) begin mis++; $display("FAIL reopen_dwell: got %0d want 9", n); end
    endtask

    task automatic test_async_reset();
        int n;
        ext_floor = 8'h40; ext_up = 8'h20; tick(); ext_floor = 8'h00; ext_up = 8'h00;
        n = 0;
        while (cur_floor !== 3'd3 && n < 100) begin tick(); n++; end
        tick();
        cmp++; if (cur_cmd !== 2'b01 || u_buttons !== 8'h20 || f_buttons !== 8'h40) begin mis++; $display("FAIL arst_pre: got %b/%h/%h want 01/20/40", cur_cmd, u_buttons, f_buttons); end
        #2 rst_n = 1'b0;
        #1;
        cmp++; if (cur_floor !== 3'd0 || cur_cmd !== 2'b00 || doors_open !== 1'b0 || dir !== 1'b1 || {u_buttons, d_buttons, f_buttons} !== 24'h0)
            begin mis++; $display("FAIL arst_now: got fl%0d cmd%b door%b dir%b btn%h want 0/00/0/1/0", cur_floor, cur_cmd, doors_open, dir, {u_buttons, d_buttons, f_buttons}); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        cmp++; if (cur_cmd !== 2'b00 || cur_floor !== 3'd0) begin mis++; $display("FAIL arst_after: got %b/%0d want 00/0", cur_cmd, cur_floor); end
    endtask

    initial begin
        test_reset();
        test_same_floor();
        test_travel();
        test_scan();
        test_door_hold();
        test_reopen();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Next-generation single-car elevator controller.
- Replaces the fixed-timing first-generation elevator_top.
- Generalised over floor count, per-floor travel time and door dwell time.
- Adds direction-collective (SCAN) scheduling, door-hold/reopen and a direction output.
- Sits between the hall/car button decoders and the motor/door drive logic.

Parameters:
N_FLOORS, 8, number of floors (>=2); F_BITS = $clog2(N_FLOORS)
TRAVEL_CYC, 4, clock cycles to travel one floor (>=1)
DOOR_CYC, 6, clock cycles doors stay open after last reload (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ext_up  input  N_FLOORS  hall-up request pulses, one bit per floor
ext_down  input  N_FLOORS  hall-down request pulses
ext_floor  input  N_FLOORS  in-car destination pulses
door_hold  input  1  level; keeps doors open while high during DOOR
cur_floor  output  F_BITS  current floor
cur_cmd  output  2  00 idle, 01 moving up, 10 moving down, 11 doors open
doors_open  output  1  high in DOOR state
dir  output  1  service direction, 1=up, 0=down
u_buttons  output  N_FLOORS  latched pending up requests
d_buttons  output  N_FLOORS  latched pending down requests
f_buttons  output  N_FLOORS  latched pending car requests

Behaviour:
- Reset (async, rst_n=0): cur_floor=0, cur_cmd=00, doors_open=0, dir=1, all button registers=0, counters=0, state=IDLE. Reset mid-move or mid-door aborts immediately and discards all pending requests.
- Latching: an input pulse in cycle k sets its bit, visible at k+1. Bits stay set until served.
  - ext_up[N_FLOORS-1] and ext_down[0] are ignored and never latched.
  - Multi-bit inputs latch all asserted bits.
- Request terms: above = any pending bit at floors > cur_floor; below = any at floors < cur_floor; here = any pending bit at cur_floor.
- State IDLE (cur_cmd=00):
  - If here: go to DOOR next cycle; serve bits at cur_floor.
  - Else if above and below: keep current dir and move in it.
  - Else if above: dir=1, go to MOVE.
  - Else if below: dir=0, go to MOVE.
  - Else stay in IDLE.
- State MOVE (cur_cmd=01/10 per dir):
  - The travel counter counts TRAVEL_CYC cycles. On the last cycle cur_floor steps ±1 and the counter clears.
  - At each new floor f, stop if any of these holds:
    - f_buttons[f]
    - dir=1 and u_buttons[f]
    - dir=0 and d_buttons[f]
    - there are no requests further in dir (reverse point)
  - Stop means enter DOOR on the same edge that updates cur_floor. Otherwise continue.
  - cur_floor never exceeds N_FLOORS-1 or goes below 0.
- State DOOR (cur_cmd=11, doors_open=1):
  - On entry, clear f_buttons[f] and the button matching dir.
  - At a reverse point (no requests further in dir), flip dir and also clear the opposite hall button.
  - The dwell counter loads DOOR_CYC.
  - The dwell counter reloads every cycle door_hold=1.
  - The dwell counter reloads on any new pulse at cur_floor for ext_floor, or for the hall button matching dir. Such a pulse is absorbed and not latched.
  - On expiry: go to MOVE if requests remain in dir; else flip dir and go to MOVE if requests remain opposite; else go to IDLE.
- Simultaneous events:
  - A pulse arriving at a bit on the same cycle that bit is cleared: the clear wins only if the pulse is at the served floor/direction. Otherwise the pulse latches.
  - Pulses on non-current floors always latch in any state.
- Stop decisions use registered button state plus same-cycle arrival floor; no combinational path from ext_* to cur_cmd.

Test Plan:
- Reset with pulses applied → cur_floor=0, cur_cmd=00, doors_open=0, dir=1, all buttons 0 until rst_n=1. Pulses during reset are not latched.
- Idle at floor 0, ext_floor=8'h01 pulse at cycle k → f_buttons[0] at k+1, doors_open from k+2 for exactly 6 cycles. The latched bit clears on DOOR entry. Then cur_cmd=00.
- Idle at floor 0, ext_floor[5] pulse → cur_cmd=01, cur_floor increments every 4 cycles, reaches 5 after 20 MOVE cycles. Doors open 6 cycles, f_buttons=0, then IDLE.
- SCAN from floor 0: ext_floor[6]; during MOVE past floor 1, ext_down[3] and ext_up[4] → stop at 4 (u_buttons[4] cleared, d_buttons[3] kept). Then stop at 6, dir flips to 0, stop at 3, d_buttons cleared, IDLE.
- At floor 2 DOOR, door_hold high 10 cycles → doors_open stays high for hold+6 cycles. An ext_floor[2] pulse mid-dwell restarts the 6-cycle count and is not latched.
- Reset asserted mid-MOVE between floors 3 and 4 with pending u_buttons/f_buttons → all outputs return to reset values asynchronously, before the next clk edge.
